// File: rtl/text_raster_scanner_pkg.sv
// Shared constants and state encoding for the character-cell raster scanner.
package text_raster_scanner_pkg;
    localparam int CHAR_W = 6;
    localparam int CHAR_H = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/text_raster_scanner_if.sv
// Line-control strobes, text-buffer and font-ROM ports, and pixel output of the scanner.
interface text_raster_scanner_if #(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int AW   = $clog2(COLS * ROWS)
);
    import text_raster_scanner_pkg::*;

    // The scanner has no back-pressure: i_pix_en is a strobe that consumes one pixel
    // per asserted cycle, and o_pixel_valid qualifies o_pixel on the following cycle.
    logic              i_frame_start;
    logic              i_line_start;
    logic              i_pix_en;
    logic [AW-1:0]     o_char_addr;
    logic [CHAR_W-1:0] i_char_data;
    logic [CHAR_W-1:0] o_font_char;
    logic [2:0]        o_font_row;
    logic [CHAR_W-1:0] i_font_raster;
    logic              o_pixel;
    logic              o_pixel_valid;
    logic              o_line_done;

    modport master (
        output i_frame_start, i_line_start, i_pix_en, i_char_data, i_font_raster,
        input  o_char_addr, o_font_char, o_font_row, o_pixel, o_pixel_valid, o_line_done
    );

    modport slave (
        input  i_frame_start, i_line_start, i_pix_en, i_char_data, i_font_raster,
        output o_char_addr, o_font_char, o_font_row, o_pixel, o_pixel_valid, o_line_done
    );
endinterface

// File: rtl/text_raster_scanner_raster_shifter.sv
// Pixel shift register for the current cell plus a hold register for the next cell's raster.
module text_raster_scanner_raster_shifter
    import text_raster_scanner_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_hold_load,
    input  logic              i_shift,
    input  logic              i_xfer,
    input  logic [CHAR_W-1:0] i_raster,
    output logic              o_msb
);
    logic [CHAR_W-1:0] shift_q, shift_d;
    logic [CHAR_W-1:0] hold_q, hold_d;

    always_comb begin
        shift_d = shift_q;
        hold_d  = hold_q;
        if (i_load) begin
            shift_d = i_raster;
        end else if (i_xfer) begin
            shift_d = hold_q;
        end else if (i_shift) begin
            shift_d = {shift_q[CHAR_W-2:0], 1'b0};
        end
        if (i_hold_load) begin
            hold_d = i_raster;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    assign o_msb = shift_q[CHAR_W-1];
endmodule

// File: rtl/text_raster_scanner.sv
// Text-mode scan-line renderer: fetches characters, looks up font rows, and streams
// pixels MSB-first with the next cell's raster prefetched so cells join without gaps.
module text_raster_scanner
    import text_raster_scanner_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    text_raster_scanner_if.slave  bus,
    output state_t                o_dbg_state
);
    localparam int AW    = $clog2(COLS * ROWS);
    localparam int LINES = ROWS * CHAR_H;
    localparam int LW    = $clog2(LINES + 1);
    localparam int CW    = $clog2(COLS);
    localparam int PW    = $clog2(CHAR_W);

    state_t            state_q, state_d;
    logic [LW-1:0]     line_q, line_d;
    logic [CW-1:0]     col_q, col_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              pf_issue_q, pf_issue_d;
    logic              rd_pend_q, rd_pend_d;
    logic [CHAR_W-1:0] font_char_q, font_char_d;
    logic              pixel_q, pixel_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic              line_done_q, line_done_d;

    logic sh_load, sh_hold, sh_shift, sh_xfer, sh_msb;

    function automatic logic [AW-1:0] cell_addr(input logic [LW-1:0] line, input logic [CW-1:0] col);
        logic [AW-1:0] row;
        row = AW'(line >> $clog2(CHAR_H));
        return AW'(row * AW'(COLS) + AW'(col));
    endfunction

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        col_d         = col_q;
        pix_cnt_d     = pix_cnt_q;
        addr_d        = addr_q;
        pf_issue_d    = 1'b0;
        rd_pend_d     = 1'b0;
        font_char_d   = rd_pend_q ? bus.i_char_data : font_char_q;
        pixel_d       = 1'b0;
        pixel_valid_d = 1'b0;
        line_done_d   = 1'b0;
        sh_load       = 1'b0;
        sh_hold       = 1'b0;
        sh_shift      = 1'b0;
        sh_xfer       = 1'b0;

        if (bus.i_frame_start) begin
            line_d    = '0;
            col_d     = '0;
            pix_cnt_d = '0;
            if (bus.i_line_start) begin
                state_d = ST_FETCH;
                addr_d  = cell_addr('0, '0);
            end else begin
                state_d = ST_IDLE;
            end
        end else if (bus.i_line_start) begin
            if (state_q == ST_IDLE) begin
                if (line_q < LW'(LINES)) begin
                    state_d   = ST_FETCH;
                    col_d     = '0;
                    pix_cnt_d = '0;
                    addr_d    = cell_addr(line_q, '0);
                end
            end else begin
                // Abort: skip to the next line without signalling completion.
                line_d    = line_q + 1'b1;
                col_d     = '0;
                pix_cnt_d = '0;
                if (line_q < LW'(LINES - 1)) begin
                    state_d = ST_FETCH;
                    addr_d  = cell_addr(line_q + 1'b1, '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    state_d   = ST_LOAD;
                    rd_pend_d = 1'b1;
                end
                ST_LOAD: begin
                    sh_load = 1'b1;
                    state_d = ST_SHIFT;
                    if (col_q != CW'(COLS - 1)) begin
                        addr_d     = cell_addr(line_q, col_q + 1'b1);
                        pf_issue_d = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    rd_pend_d = pf_issue_q;
                    sh_hold   = rd_pend_q;
                    if (bus.i_pix_en) begin
                        pixel_d       = sh_msb;
                        pixel_valid_d = 1'b1;
                        if (pix_cnt_q == PW'(CHAR_W - 1)) begin
                            pix_cnt_d = '0;
                            if (col_q == CW'(COLS - 1)) begin
                                state_d = ST_DONE;
                            end else begin
                                sh_xfer = 1'b1;
                                col_d   = col_q + 1'b1;
                                if (col_q != CW'(COLS - 2)) begin
                                    addr_d     = cell_addr(line_q, col_q + CW'(2));
                                    pf_issue_d = 1'b1;
                                end
                            end
                        end else begin
                            sh_shift  = 1'b1;
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    line_done_d = 1'b1;
                    line_d      = line_q + 1'b1;
                    col_d       = '0;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            line_q        <= '0;
            col_q         <= '0;
            pix_cnt_q     <= '0;
            addr_q        <= '0;
            pf_issue_q    <= 1'b0;
            rd_pend_q     <= 1'b0;
            font_char_q   <= '0;
            pixel_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            line_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            col_q         <= col_d;
            pix_cnt_q     <= pix_cnt_d;
            addr_q        <= addr_d;
            pf_issue_q    <= pf_issue_d;
            rd_pend_q     <= rd_pend_d;
            font_char_q   <= font_char_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            line_done_q   <= line_done_d;
        end
    end

    text_raster_scanner_raster_shifter u_shifter (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (sh_load),
        .i_hold_load (sh_hold),
        .i_shift     (sh_shift),
        .i_xfer      (sh_xfer),
        .i_raster    (bus.i_font_raster),
        .o_msb       (sh_msb)
    );

    // While a read is returning, the font ROM is addressed straight from the RAM data.
    assign bus.o_font_char   = rd_pend_q ? bus.i_char_data : font_char_q;
    assign bus.o_font_row    = line_q[2:0];
    assign bus.o_char_addr   = addr_q;
    assign bus.o_pixel       = pixel_q;
    assign bus.o_pixel_valid = pixel_valid_q;
    assign bus.o_line_done   = line_done_q;
    assign o_dbg_state       = state_q;
endmodule
